// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: pointer/count widths and a
// parameter sanity check used at elaboration of sync_fifo_param.
package fifo_pkg;

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // DEPTH must be a power of two >= 2; thresholds must lie in their legal ranges.
  function automatic bit params_ok(input int depth, input int af_level, input int ae_level);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, almost-full/empty thresholds and
// sticky overflow/underflow flags. Define SYNC_FIFO_FWFT_EN for first-word fall-through output.
module sync_fifo_param import fifo_pkg::*; #(
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 8,
  parameter  int AF_LEVEL = 6,
  parameter  int AE_LEVEL = 2,
  localparam int CNT_W    = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int               PTR_W  = ptr_width(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL");
  end

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A simultaneous read frees the slot a full FIFO would otherwise refuse.
  assign wr_acc = wr && (!full || rd);
  assign rd_acc = rd && !empty;

  always_comb begin
    wr_ptr_d    = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Setting a new error takes priority over a same-cycle clear.
    overflow_d  = (wr && full && !rd) ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
    underflow_d = (rd && empty)       ? 1'b1 : (err_clr ? 1'b0 : underflow_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem_rdata;
`else
  logic [DATA_W-1:0] data_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      data_out_q <= '0;
    else if (rd_acc) data_out_q <= mem_rdata;
  end

  assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=8, AF=6, AE=2), both output modes.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0, rd = 1'b0, err_clr = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: a queue plus sticky flags and the standard-mode output word.
  byte unsigned q[$];
  bit           m_ovf = 0, m_unf = 0;
  byte unsigned m_dout = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_data_out();
`ifdef SYNC_FIFO_FWFT_EN
    return (q.size() == 0) ? 0 : int'(q[0]);
`else
    return int'(m_dout);
`endif
  endfunction

  task automatic compare_all();
    chk("count",        int'(count),        q.size());
    chk("full",         int'(full),         int'(q.size() == 8));
    chk("empty",        int'(empty),        int'(q.size() == 0));
    chk("almost_full",  int'(almost_full),  int'(q.size() >= 6));
    chk("almost_empty", int'(almost_empty), int'(q.size() <= 2));
    chk("overflow",     int'(overflow),     int'(m_ovf));
    chk("underflow",    int'(underflow),    int'(m_unf));
    chk("data_out",     int'(data_out),     exp_data_out());
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 0;
    m_unf  = 0;
    m_dout = 0;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
  task automatic step(input bit w, input byte unsigned d, input bit r, input bit c);
    bit           is_full, is_empty, wacc, racc;
    byte unsigned popped;
    wr = w; data_in = d; rd = r; err_clr = c;
    @(posedge clk);
    is_full  = (q.size() == 8);
    is_empty = (q.size() == 0);
    wacc     = w && (!is_full || r);
    racc     = r && !is_empty;
    if (racc) begin
      popped = q.pop_front();
      m_dout = popped;
    end
    if (wacc) q.push_back(d);
    if (w && is_full && !r) m_ovf = 1;
    else if (c)             m_ovf = 0;
    if (r && is_empty)      m_unf = 1;
    else if (c)             m_unf = 0;
    @(negedge clk);
    compare_all();
    wr = 0; rd = 0; err_clr = 0;
    $display("step wr=%0b din=%0d rd=%0b clr=%0b -> count=%0d dout=%0d ovf=%0b unf=%0b",
             w, d, r, c, count, data_out, overflow, underflow);
  endtask

  // Read one word and pin its value with a hand-computed literal.
  task automatic read_expect(input string name, input int lit);
`ifdef SYNC_FIFO_FWFT_EN
    chk(name, int'(data_out), lit);
    step(0, 0, 1, 0);
`else
    step(0, 0, 1, 0);
    chk(name, int'(data_out), lit);
`endif
  endtask

  initial begin
    byte unsigned wvals[8] = '{12, 22, 16, 4, 25, 36, 17, 28};

    // Reset then idle
    #12;
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk("reset_count_lit", int'(count), 0);
    chk("reset_ae_lit", int'(almost_empty), 1);

    // Fill with the reference sequence, pinning flag thresholds
    for (int i = 0; i < 8; i++) begin
      step(1, wvals[i], 0, 0);
      if (i == 2) chk("ae_drops_at_3", int'(almost_empty), 0);
      if (i == 4) chk("af_low_at_5",   int'(almost_full), 0);
      if (i == 5) chk("af_at_6",       int'(almost_full), 1);
    end
    chk("full_at_8", int'(full), 1);

    // Overflow: write 99 while full; it must never come out
    step(1, 99, 0, 0);
    chk("ovf_lit", int'(overflow), 1);
    chk("ovf_count_lit", int'(count), 8);
    for (int i = 0; i < 8; i++) read_expect($sformatf("drain%0d", i), int'(wvals[i]));
    chk("empty_after_drain", int'(empty), 1);
    step(0, 0, 0, 1);
    chk("ovf_cleared", int'(overflow), 0);

    // Full with simultaneous wr+rd: no overflow, 55 comes out last
    for (int i = 0; i < 8; i++) step(1, byte'(40 + i), 0, 0);
    step(1, 55, 1, 0);
    chk("wrrd_full_count", int'(count), 8);
    chk("wrrd_full_noovf", int'(overflow), 0);
    for (int i = 1; i < 8; i++) read_expect($sformatf("post%0d", i), 40 + i);
    read_expect("last55", 55);

    // Empty with simultaneous wr+rd: underflow, 7 is stored
    step(1, 7, 1, 0);
    chk("unf_lit", int'(underflow), 1);
    chk("unf_count_lit", int'(count), 1);
    read_expect("read7", 7);
    // err_clr together with a fresh underflow: set wins
    step(0, 0, 1, 1);
    chk("unf_set_wins", int'(underflow), 1);
    step(0, 0, 0, 1);

    // Asynchronous reset mid-cycle after three writes
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    step(1, 3, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("async_rst_count", int'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // Wrap: prefill 3, then 20 interleaved writes and reads, then drain
    for (int i = 0; i < 3; i++) step(1, byte'(200 + i), 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) step(1, byte'(100 + i), 1, 0);
      else begin
        step(1, byte'(100 + i), 0, 0);
        step(0, 0, 1, 0);
      end
    end
    while (q.size() != 0 && n_vec < 5000) step(0, 0, 1, 0);
    chk("wrap_empty", int'(empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
